// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch feeding decode through a DEPTH-entry prefetch FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response arriving at an empty queue straight to out.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  inflight_pc;
    logic             inflight;
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             queue_empty;
    logic             resp_valid;
    logic             bypass_take;
    logic             push;
    logic             pop;
    logic             unused_bits;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_bits = ^redirect_pc[1:0];
    assign queue_empty = (count == '0);
    assign resp_valid  = inflight && !redirect_valid;

    // Credit rule: queued plus outstanding words never exceed DEPTH, so a push cannot overflow.
    assign imem_req  = !reset && !redirect_valid &&
                       (({1'b0, count} + (CNT_W + 1)'(inflight)) < (CNT_W + 1)'(DEPTH));
    assign imem_addr = fetch_pc;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit  = queue_empty && resp_valid;
    assign bypass_take = bypass_hit && out_ready;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (!queue_empty) begin
            out_valid = !redirect_valid;
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end else if (bypass_hit) begin
            out_valid = 1'b1;
            out_pc    = inflight_pc;
            out_instr = imem_rdata;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (!queue_empty) begin
            out_valid = !redirect_valid;
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end
`endif

    assign push = resp_valid && !bypass_take;
    assign pop  = out_valid && out_ready && !queue_empty;

    // Fetch PC, in-flight tracking and queue bookkeeping; redirect outranks push and pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (imem_req) begin
                    fetch_pc    <= fetch_pc + XLEN'(4);
                    inflight_pc <= fetch_pc;
                end
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It keeps its own fetch PC and issues sequential requests to a synchronous instruction memory with one cycle of read latency. Returned words are buffered, with their PCs, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. A branch/jump redirect flushes the queue and any in-flight request. The block replaces the fixed PC/IF-ID register pair with a stallable, flushable front end.

## Interface
- XLEN, 32, PC and instruction width.
- DEPTH, 4, queue entries; must be ≥2; full throughput requires ≥3.
- RESET_PC, 0, fetch address after reset.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  input  XLEN  new fetch address; bits [1:0] are ignored and treated as 0.
- imem_req  output  1  read request this cycle.
- imem_addr  output  XLEN  read address, equal to fetch_pc.
- imem_rdata  input  XLEN  read data, valid the cycle after imem_req.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  XLEN  PC of the head instruction (the instruction's own address, not PC+4).
- out_instr  output  XLEN  head instruction.
- count  output  $clog2(DEPTH+1)  queue occupancy.

## Operation
- State:
  - fetch_pc
  - inflight (1 bit: a request was issued last cycle)
  - circular FIFO of {pc, instr}
  - rd_ptr, wr_ptr and count
  - inflight_pc, the address of the outstanding request
- Issue: imem_req = !reset && !redirect_valid && (count + inflight) < DEPTH.
  - On issue, fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN; inflight_pc ← fetch_pc.
  - inflight ← imem_req.
- Response: when inflight=1 and redirect_valid=0, push {inflight_pc, imem_rdata}.
  - The credit rule guarantees the push never overflows.
- Pop: when out_valid && out_ready, the head is removed.
  - A push and a pop in the same cycle leave count unchanged.
- Redirect, in cycle t:
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}; count ← 0; pointers ← 0.
  - The response arriving in t is discarded; no request is issued in t.
  - out_valid = 0 in t, and out_ready is ignored.
  - Redirect has priority over push and pop.
- Empty queue: out_valid = 0, and out_pc = out_instr = 0 (except under bypass, see Configuration).
- Full queue: no issue, since the credit rule blocks it; the PC holds.

## Timing
- Reset values, next edge after reset=1:
  - fetch_pc = RESET_PC
  - inflight = 0, count = 0, pointers = 0
  - out_valid = 0, out_pc = 0, out_instr = 0
- imem_req = 0 while reset is high.
- First request is in the first cycle with reset low.
- Latency, request to out_valid:
  - 2 cycles without bypass: request in c, data in c+1, enters the queue at the c+1 edge, out_valid in c+2.
- Redirect to first redirected instruction on out_valid:
  - t+3 without bypass
  - t+2 with bypass
- Steady state with out_ready held high and DEPTH ≥ 3: one instruction per cycle.
- Reset mid-operation: all queue contents and the in-flight response are dropped. A response arriving in the cycle after reset deasserts is discarded, because inflight is 0.
- Simultaneous redirect and reset: reset wins, and fetch_pc = RESET_PC.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and a valid response arrives (inflight=1, redirect_valid=0), it is driven combinationally on out_valid/out_pc/out_instr in the same cycle.
  - If out_ready=1 that cycle, the word is consumed and not pushed.
  - Otherwise it is pushed as normal.
- FETCH_QUEUE_BYPASS_EN undefined:
  - Outputs come only from the FIFO head, giving a registered output path and 2-cycle latency.

## Test plan
- Reset, then out_ready=1 for 10 cycles:
  - imem_addr runs 0,4,8,… every cycle.
  - out_pc runs 0,4,8,… one per cycle, starting cycle 2 (cycle 1 with bypass).
- out_ready=0 from reset:
  - Exactly DEPTH requests are issued; count reaches DEPTH (4) and then imem_req stays 0.
  - Raising out_ready drains PCs 0,4,8,12 in order.
- Redirect to 0x103 while 3 entries are queued and a request is in flight:
  - Next cycle count=0.
  - imem_addr=0x100 on the cycle after the redirect.
  - The stale response never appears on out; first out_pc=0x100.
- Alternate out_ready 1/0 every cycle for 20 cycles:
  - No lost or duplicated PCs; count never exceeds DEPTH.
- Reset asserted with 2 entries queued:
  - out_valid=0 and count=0 after the edge.
  - Restart fetches from RESET_PC=0x200 (parameter override).
- fetch_pc=0xFFFFFFFC:
  - The next request address wraps to 0x00000000.
